change_dispense_ctrl: RTL and testbench
=======================================

Name: change_dispense_ctrl

Overview:
- Sequences change return after a vend: converts a change amount in nickels into a series of single-coin requests to three coin hoppers (5c, 10c, 20c) using a 4-phase req/ack handshake.
- Sits between the vending FSM, which supplies the change amount and a start pulse, and the hopper drivers (r5/r10/r20 outputs).
- Uses greedy coin selection, skips empty or jammed hoppers, and reports done or shortfall.

Parameters:
- CNT_W, 4, width of the change amount in nickels (max 15 = 75c).
- ACK_TIMEOUT, 1000, cycles to wait for hop_ack before the hopper is declared jammed.
- TO_W, 10, width of the timeout counter; must satisfy 2^TO_W > ACK_TIMEOUT.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin dispensing change_in.
- change_in  in  CNT_W  change owed, in nickels; sampled on start.
- hop_ack  in  3  per-hopper acknowledge; bit0=5c, bit1=10c, bit2=20c.
- hop_empty  in  3  per-hopper empty flag, same bit order.
- hop_req  out  3  one-hot coin request, same bit order.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when the sequence ends, on success or fault.
- error  out  1  sticky shortfall flag.
- remaining  out  CNT_W  nickels still owed.

Behaviour:
- Reset: state=IDLE; hop_req=0, busy=0, done=0, error=0, remaining=0, jam mask=000, timeout counter=0. All outputs are registered.
- States: IDLE, SELECT, REQ, RELEASE, FIN, FAULT.
- IDLE: start=1 → remaining<=change_in, error<=0, jam<=000, go to SELECT; busy=1 from the next cycle. start while busy is ignored.
- SELECT: avail[i] = ~hop_empty[i] & ~jam[i]. Priority:
  - remaining==0 → FIN.
  - remaining>=4 & avail[2] → hop_req<=100.
  - else remaining>=2 & avail[1] → hop_req<=010.
  - else avail[0] → hop_req<=001.
  - else → FAULT.
  - Issuing a request clears the timeout counter and goes to REQ. hop_req is asserted the cycle after SELECT; it first appears 2 cycles after start.
- REQ: hop_req holds.
  - If the ack bit for the active coin is high: remaining -= 4, 2 or 1 (never underflows, guaranteed by selection); hop_req<=0; go to RELEASE.
  - Else if counter == ACK_TIMEOUT-1: jam[active] <= 1; hop_req<=0; go to RELEASE.
  - Else counter increments.
- RELEASE: wait until the active ack bit is 0, then go to SELECT (4-phase completion). A timed-out hopper whose ack is already low passes through in 1 cycle.
- hop_ack bits for inactive coins are ignored.
- FIN: done=1 for one cycle, busy<=0, go to IDLE.
- FAULT: error<=1, done=1 for one cycle, busy<=0, go to IDLE. remaining holds the shortfall until the next accepted start.
- Simultaneous ack and timeout on the same cycle: ack wins.
- hop_empty rising during REQ does not abort the request; emptiness is only evaluated in SELECT.
- Reset mid-operation: hop_req drops immediately (async); no partial-coin accounting is retained.
- hop_req is never more than one-hot; hop_req=0 in IDLE, RELEASE, FIN and FAULT.

Optional Feature:
- Macro COIN_AUDIT_EN.
- Defined: adds output ports audit_5, audit_10 and audit_20, each 8 bits. Each is a saturating count (max 255) of acked coins for that denomination. Counters clear only on reset and are not cleared by start.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- change_in=7, all hoppers full, ack returned 3 cycles after each req → reqs in order 100, 010, 001; remaining 7→3→1→0; done pulse; error=0.
- change_in=0 → no hop_req ever asserted; done pulse 2 cycles after start; busy high for exactly 1 cycle; error=0.
- change_in=4, hop_empty=100 → two 010 requests; remaining 4→2→0; done; error=0.
- change_in=2, 10c hopper never acks, ACK_TIMEOUT=8 → 010 held 8 cycles then dropped; then two 001 requests; done; error=0.
- change_in=1, hop_empty=001 → no req; error=1, remaining=1, done pulse; a new start with change_in=0 clears error.
- reset asserted during REQ with hop_req=100 → hop_req=000 and busy=0 in the same cycle; state IDLE after release; with COIN_AUDIT_EN defined, audit counters read 0.

Source files
------------

// File: rtl/change_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : change_dispense_ctrl
// Description : Turns a change amount (in nickels) into a sequence of
//               single-coin requests to 5c/10c/20c hoppers using a 4-phase
//               req/ack handshake. Coins are chosen greedily. Empty or jammed
//               hoppers are skipped, and the block reports done or shortfall.
// Option      : COIN_AUDIT_EN adds saturating per-denomination coin counters
//               (audit_5, audit_10, audit_20).
// Revision    : 1.0 - initial release
// ============================================================================
module change_dispense_ctrl #(
    parameter int CNT_W       = 4,
    parameter int ACK_TIMEOUT = 1000,
    parameter int TO_W        = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] change_in,
    input  logic [2:0]       hop_ack,
    input  logic [2:0]       hop_empty,
    output logic [2:0]       hop_req,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] remaining
`ifdef COIN_AUDIT_EN
    ,
    output logic [7:0]       audit_5,
    output logic [7:0]       audit_10,
    output logic [7:0]       audit_20
`endif
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        SELECT  = 3'd1,
        REQ     = 3'd2,
        RELEASE = 3'd3,
        FIN     = 3'd4,
        FAULT   = 3'd5
    } state_t;

    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

    state_t           state, state_nxt;
    logic [2:0]       hop_req_nxt;
    logic             busy_nxt, done_nxt, error_nxt;
    logic [CNT_W-1:0] remaining_nxt;
    logic [2:0]       jam, jam_nxt;      // hoppers that timed out this sequence
    logic [2:0]       act, act_nxt;      // coin being handled, kept through RELEASE
    logic [TO_W-1:0]  tcnt, tcnt_nxt;    // cycles spent waiting in REQ
    logic [2:0]       avail;
    logic             ack_hit;
    logic [CNT_W-1:0] coin_val;

    assign avail   = ~hop_empty & ~jam;
    assign ack_hit = |(hop_ack & act);

    // Value in nickels of the coin currently being handled
    always_comb begin
        coin_val = CNT_W'(1);
        if (act[2])
            coin_val = CNT_W'(4);
        else if (act[1])
            coin_val = CNT_W'(2);
    end

    // Registered state and outputs; reset drops hop_req at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            hop_req   <= 3'b000;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
            remaining <= '0;
            jam       <= 3'b000;
            act       <= 3'b000;
            tcnt      <= '0;
        end else begin
            state     <= state_nxt;
            hop_req   <= hop_req_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            error     <= error_nxt;
            remaining <= remaining_nxt;
            jam       <= jam_nxt;
            act       <= act_nxt;
            tcnt      <= tcnt_nxt;
        end
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    // so that done/busy/error/hop_req are all straight from flops
    always_comb begin
        state_nxt     = state;
        hop_req_nxt   = hop_req;
        busy_nxt      = busy;
        done_nxt      = 1'b0;
        error_nxt     = error;
        remaining_nxt = remaining;
        jam_nxt       = jam;
        act_nxt       = act;
        tcnt_nxt      = tcnt;

        case (state)
            IDLE: begin
                if (start) begin
                    remaining_nxt = change_in;
                    error_nxt     = 1'b0;
                    jam_nxt       = 3'b000;
                    busy_nxt      = 1'b1;
                    state_nxt     = SELECT;
                end
            end

            SELECT: begin
                if (remaining == '0) begin
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = FIN;
                end else if (remaining >= CNT_W'(4) && avail[2]) begin
                    hop_req_nxt = 3'b100;
                    act_nxt     = 3'b100;
                    tcnt_nxt    = '0;
                    state_nxt   = REQ;
                end else if (remaining >= CNT_W'(2) && avail[1]) begin
                    hop_req_nxt = 3'b010;
                    act_nxt     = 3'b010;
                    tcnt_nxt    = '0;
                    state_nxt   = REQ;
                end else if (avail[0]) begin
                    hop_req_nxt = 3'b001;
                    act_nxt     = 3'b001;
                    tcnt_nxt    = '0;
                    state_nxt   = REQ;
                end else begin
                    // Change still owed but no usable hopper can supply it
                    error_nxt = 1'b1;
                    done_nxt  = 1'b1;
                    busy_nxt  = 1'b0;
                    state_nxt = FAULT;
                end
            end

            REQ: begin
                // Ack is checked first so it wins over a coincident timeout
                if (ack_hit) begin
                    remaining_nxt = remaining - coin_val;
                    hop_req_nxt   = 3'b000;
                    state_nxt     = RELEASE;
                end else if (tcnt == TO_LAST) begin
                    jam_nxt     = jam | act;
                    hop_req_nxt = 3'b000;
                    state_nxt   = RELEASE;
                end else begin
                    tcnt_nxt = tcnt + TO_W'(1);
                end
            end

            RELEASE: begin
                if (!ack_hit)
                    state_nxt = SELECT;
            end

            FIN, FAULT: begin
                state_nxt = IDLE;
            end

            default: begin
                hop_req_nxt = 3'b000;
                busy_nxt    = 1'b0;
                state_nxt   = IDLE;
            end
        endcase
    end

`ifdef COIN_AUDIT_EN
    logic coin_taken;
    assign coin_taken = (state == REQ) && ack_hit;

    // Saturating counts of acknowledged coins; only reset clears them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            audit_5  <= 8'd0;
            audit_10 <= 8'd0;
            audit_20 <= 8'd0;
        end else if (coin_taken) begin
            if (act[0] && audit_5 != 8'hFF)
                audit_5 <= audit_5 + 8'd1;
            if (act[1] && audit_10 != 8'hFF)
                audit_10 <= audit_10 + 8'd1;
            if (act[2] && audit_20 != 8'hFF)
                audit_20 <= audit_20 + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_change_dispense_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_change_dispense_ctrl
// Description : Self-checking bench for change_dispense_ctrl. A behavioural
//               hopper responder answers requests; a transaction-level greedy
//               change model predicts the coin sequence, hold times, final
//               remaining amount and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_change_dispense_ctrl;

    localparam int CNT_W       = 4;
    localparam int ACK_TIMEOUT = 8;
    localparam int TO_W        = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] change_in;
    logic [2:0]       hop_ack;
    logic [2:0]       hop_empty;
    logic [2:0]       hop_req;
    logic             busy, done, error;
    logic [CNT_W-1:0] remaining;
`ifdef COIN_AUDIT_EN
    logic [7:0]       audit_5, audit_10, audit_20;
`endif

    change_dispense_ctrl #(
        .CNT_W(CNT_W), .ACK_TIMEOUT(ACK_TIMEOUT), .TO_W(TO_W)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .change_in(change_in),
        .hop_ack(hop_ack), .hop_empty(hop_empty), .hop_req(hop_req),
        .busy(busy), .done(done), .error(error), .remaining(remaining)
`ifdef COIN_AUDIT_EN
        , .audit_5(audit_5), .audit_10(audit_10), .audit_20(audit_20)
`endif
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // monitor state
    logic [2:0] prev_req = 3'b000;
    int         hold;
    logic [2:0] req_log[$];
    int         hold_log[$];
    int         first_req_cyc;
    int         done_cnt;
    int         busy_cnt;

    // hopper responder state
    logic [2:0] dead;
    logic [2:0] ack_drv;
    int         dly[3];
    int         rel[3];
    int         wcnt[3];
    int         rcnt[3];

    // expected audit totals
    int         exp_a[3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock: sample DUT just after the edge, then update hopper acks
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        check("onehot", 32'($countones(hop_req) <= 1), 32'd1);
        if (hop_req != 3'b000 && prev_req == 3'b000) begin
            req_log.push_back(hop_req);
            hold = 0;
            if (first_req_cyc < 0) first_req_cyc = cyc;
        end
        if (hop_req != 3'b000) hold++;
        if (hop_req == 3'b000 && prev_req != 3'b000) hold_log.push_back(hold);
        if (done === 1'b1) done_cnt++;
        if (busy === 1'b1) busy_cnt++;
        for (int i = 0; i < 3; i++) begin
            if (hop_req[i]) begin
                if (!dead[i] && wcnt[i] >= dly[i]) ack_drv[i] = 1'b1;
                wcnt[i]++;
            end else begin
                wcnt[i] = 0;
                if (ack_drv[i]) begin
                    if (rcnt[i] >= rel[i]) begin
                        ack_drv[i] = 1'b0;
                        rcnt[i]    = 0;
                    end else begin
                        rcnt[i]++;
                    end
                end
            end
        end
        hop_ack  = ack_drv;
        prev_req = hop_req;
    endtask

    // One full dispense sequence checked against the greedy model
    task automatic run_txn(input logic [3:0] chg, input logic [2:0] empty,
                           input logic [2:0] dd, input int fixed_dly);
        logic [2:0] exp_q[$];
        int         exp_h[$];
        int         rem;
        logic [2:0] jm;
        logic       err;
        int         val[3] = '{1, 2, 4};
        int         s;
        int         guard;
        bit         inject;

        for (int i = 0; i < 3; i++) begin
            dly[i]  = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, 5));
            rel[i]  = int'($urandom_range(0, 2));
            wcnt[i] = 0;
            rcnt[i] = 0;
        end

        rem = int'(chg);
        jm  = 3'b000;
        err = 1'b0;
        while (rem > 0) begin
            int k;
            k = -1;
            for (int j = 2; j >= 0; j--)
                if (k < 0 && rem >= val[j] && !empty[j] && !jm[j]) k = j;
            if (k < 0) begin
                err = 1'b1;
                break;
            end
            exp_q.push_back(3'(1 << k));
            if (dd[k]) begin
                jm[k] = 1'b1;
                exp_h.push_back(ACK_TIMEOUT);
            end else begin
                rem -= val[k];
                exp_h.push_back(dly[k] + 1);
                if (exp_a[k] < 255) exp_a[k]++;
            end
        end

        hop_empty = empty;
        dead      = dd;
        req_log.delete();
        hold_log.delete();
        first_req_cyc = -1;
        done_cnt      = 0;
        busy_cnt      = 0;

        start     = 1'b1;
        change_in = chg;
        tick();
        start     = 1'b0;
        change_in = 4'($urandom);
        s         = cyc;
        check("busy_on", busy, 1);

        inject = ($urandom_range(0, 3) == 0);
        guard  = 0;
        while (done !== 1'b1 && guard < 1000) begin
            if (inject && busy && !done && cyc == s + 2) begin
                start     = 1'b1;
                change_in = 4'hF;
            end
            tick();
            start = 1'b0;
            guard++;
        end
        if (guard >= 1000) begin
            check("done_timeout", 0, 1);
            return;
        end

        if (chg == 0) begin
            check("zero_done_lat", cyc - s, 1);
            check("zero_busy_cycles", busy_cnt, 1);
        end
        if (exp_q.size() > 0) check("first_req_lat", first_req_cyc - s, 1);
        check("busy_at_done", busy, 0);
        check("error", error, err);
        check("remaining", remaining, rem);
        check("req_count", req_log.size(), exp_q.size());
        check("hold_count", hold_log.size(), exp_h.size());
        for (int i = 0; i < exp_q.size() && i < req_log.size(); i++)
            check("req_coin", req_log[i], exp_q[i]);
        for (int i = 0; i < exp_h.size() && i < hold_log.size(); i++)
            check("req_hold", hold_log[i], exp_h[i]);
`ifdef COIN_AUDIT_EN
        check("audit_5", audit_5, exp_a[0]);
        check("audit_10", audit_10, exp_a[1]);
        check("audit_20", audit_20, exp_a[2]);
`endif
        tick();
        check("done_pulse_end", done, 0);
        check("done_pulse_count", done_cnt, 1);
    endtask

    initial begin
        int guard;
        reset     = 1'b1;
        start     = 1'b0;
        change_in = '0;
        hop_ack   = 3'b000;
        hop_empty = 3'b000;
        ack_drv   = 3'b000;
        dead      = 3'b000;
        for (int i = 0; i < 3; i++) begin
            exp_a[i] = 0; dly[i] = 0; rel[i] = 0; wcnt[i] = 0; rcnt[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_hop_req", hop_req, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_error", error, 0);
        check("rst_remaining", remaining, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // directed cases
        run_txn(4'd7, 3'b000, 3'b000, 3);
        run_txn(4'd0, 3'b000, 3'b000, -1);
        run_txn(4'd4, 3'b100, 3'b000, -1);
        run_txn(4'd2, 3'b000, 3'b010, -1);
        run_txn(4'd1, 3'b001, 3'b000, -1);
        run_txn(4'd0, 3'b000, 3'b000, -1);
        run_txn(4'd15, 3'b000, 3'b100, -1);
        run_txn(4'd15, 3'b110, 3'b000, -1);

        // randomized cases
        for (int n = 0; n < 40; n++) begin
            logic [2:0] e;
            logic [2:0] d;
            e = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'b000;
            d = ($urandom_range(0, 4) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
            run_txn(4'($urandom_range(0, 15)), e, d, -1);
        end

        // reset while a 20c request is outstanding
        hop_empty = 3'b000;
        dead      = 3'b100;
        start     = 1'b1;
        change_in = 4'd4;
        tick();
        start = 1'b0;
        guard = 0;
        while (hop_req !== 3'b100 && guard < 20) begin
            tick();
            guard++;
        end
        check("rst_mid_req_seen", hop_req, 3'b100);
        tick();
        reset = 1'b1;
        #1;
        check("rst_mid_hop_req", hop_req, 0);
        check("rst_mid_busy", busy, 0);
        for (int i = 0; i < 3; i++) exp_a[i] = 0;
        ack_drv = 3'b000;
        hop_ack = 3'b000;
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("post_rst_busy", busy, 0);
        check("post_rst_done", done, 0);
        check("post_rst_remaining", remaining, 0);
        check("post_rst_hop_req", hop_req, 0);
`ifdef COIN_AUDIT_EN
        check("post_rst_audit_5", audit_5, 0);
        check("post_rst_audit_10", audit_10, 0);
        check("post_rst_audit_20", audit_20, 0);
`endif
        run_txn(4'd7, 3'b000, 3'b000, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
